// File: rtl/register3_bit_pkg.sv
// Shared defaults, data type and per-bit next-state rule for the register3_bit slice.
package register3_bit_pkg;

    localparam int DEF_WIDTH = 3;
    localparam logic [DEF_WIDTH-1:0] DEF_SET_VALUE   = 3'b001;
    localparam logic [DEF_WIDTH-1:0] DEF_RESET_VALUE = 3'b000;

    typedef logic [DEF_WIDTH-1:0] data_t;

    // Priority: active-low reset, then set, then load, else hold.
    function automatic logic select_bit(
        input logic rst_n,
        input logic set_en,
        input logic load_en,
        input logic d,
        input logic q,
        input logic set_bit,
        input logic reset_bit
    );
        logic nxt;
        nxt = q;
        if (!rst_n) begin
            nxt = reset_bit;
        end else if (set_en) begin
            nxt = set_bit;
        end else if (load_en) begin
            nxt = d;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/register_bit_cell.sv
// One storage bit with synchronous active-low reset, preset to a fixed bit, load and hold.
module register_bit_cell
    import register3_bit_pkg::*;
#(
    parameter logic SET_BIT   = 1'b0,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic set,
    input  logic load,
    input  logic d,
    output logic q
);

    always_ff @(posedge clock) begin
        q <= select_bit(reset, set, load, d, q, SET_BIT, RESET_BIT);
    end

endmodule

// File: rtl/register3_bit.sv
// WIDTH-bit register with synchronous reset/set/load, built from one cell per bit.
module register3_bit
    import register3_bit_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SET_VALUE   = WIDTH'(DEF_SET_VALUE),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEF_RESET_VALUE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Each cell gets its own bit of the preset and reset words.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        register_bit_cell #(
            .SET_BIT  (SET_VALUE[i]),
            .RESET_BIT(RESET_VALUE[i])
        ) u_cell (
            .clock(clock),
            .reset(reset),
            .set  (set),
            .load (load),
            .d    (in[i]),
            .q    (out[i])
        );
    end

endmodule

// File: tb/tb_register3_bit.sv
// Self-checking bench: directed scenarios plus random stimulus against a priority-rule model.
module tb_register3_bit;
    import register3_bit_pkg::*;

    logic  clock;
    logic  reset;
    logic  set;
    logic  load;
    data_t in;
    data_t out;

    int total;
    int bad;
    data_t model;

    register3_bit dut (
        .clock(clock),
        .reset(reset),
        .set  (set),
        .load (load),
        .in   (in),
        .out  (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input data_t got, input data_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", tag, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, then compare 1 time unit later.
    task automatic step(input logic r, input logic s, input logic l, input data_t d,
                        input string tag);
        reset = r;
        set   = s;
        load  = l;
        in    = d;
        @(posedge clock);
        if (!r)      model = 3'b000;
        else if (s)  model = 3'b001;
        else if (l)  model = d;
        #1;
        chk(tag, out, model);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model = 3'b000;
        reset = 1'b1;
        set   = 1'b0;
        load  = 1'b0;
        in    = 3'b000;
        @(negedge clock);

        // Reset wins over set and load.
        step(1'b0, 1'b1, 1'b1, 3'b111, "reset_over_set_load");
        chk("reset_value", out, 3'b000);

        // Load then hold for three edges.
        step(1'b1, 1'b0, 1'b1, 3'b101, "load_101");
        chk("load_101_abs", out, 3'b101);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'b010, "hold_101");

        // Set loads whole word, clearing bit 2.
        step(1'b1, 1'b1, 1'b0, 3'b000, "set_word");
        chk("set_word_abs", out, 3'b001);

        // Set beats load.
        step(1'b1, 1'b0, 1'b1, 3'b111, "load_111");
        step(1'b1, 1'b1, 1'b1, 3'b110, "set_over_load");
        chk("set_over_load_abs", out, 3'b001);

        // Reset asserted mid-cycle has no effect until the edge.
        reset = 1'b0;
        #3;
        chk("reset_midcycle_hold", out, 3'b001);
        @(negedge clock);
        chk("reset_before_edge", out, 3'b001);
        @(posedge clock);
        model = 3'b000;
        #1;
        chk("reset_at_edge", out, 3'b000);

        // Deassert reset, load, then toggle in every half-cycle with controls idle.
        step(1'b1, 1'b0, 1'b1, 3'b011, "load_011");
        reset = 1'b1;
        set   = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in = data_t'($urandom);
            @(clock);
            #1;
            chk("in_toggle_no_effect", out, 3'b011);
        end
        step(1'b1, 1'b0, 1'b1, 3'b010, "load_010");
        chk("load_010_abs", out, 3'b010);

        // Consecutive loads re-sample each edge.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, data_t'(i + 4), "load_burst");

        // Glitches between edges must not matter: only the final values at the edge count.
        for (int i = 0; i < 200; i++) begin
            logic r, s, l;
            data_t d;
            reset = $urandom_range(0, 1);
            set   = $urandom_range(0, 1);
            load  = $urandom_range(0, 1);
            in    = data_t'($urandom);
            #2;
            r = ($urandom_range(0, 7) != 0);
            s = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 1) == 0);
            d = data_t'($urandom);
            step(r, s, l, d, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
